// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit and ALU_controller:
// opcode map, FSM state encoding and small opcode classification helpers.
package cpu_ctrl_pkg;

    localparam int unsigned OPCODE_W = 4;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_LD    = 4'd0;
    localparam opcode_t OP_ST    = 4'd1;
    localparam opcode_t OP_ADD   = 4'd2;
    localparam opcode_t OP_SUB   = 4'd3;
    localparam opcode_t OP_INV   = 4'd4;
    localparam opcode_t OP_LSL   = 4'd5;
    localparam opcode_t OP_LSR   = 4'd6;
    localparam opcode_t OP_AND   = 4'd7;
    localparam opcode_t OP_OR    = 4'd8;
    localparam opcode_t OP_SLT   = 4'd9;
    localparam opcode_t OP_ILL_A = 4'd10;
    localparam opcode_t OP_BEQ   = 4'd11;
    localparam opcode_t OP_BNE   = 4'd12;
    localparam opcode_t OP_JMP   = 4'd13;
    localparam opcode_t OP_ILL_E = 4'd14;
    localparam opcode_t OP_HALT  = 4'd15;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    // LD/ST use the immediate as ALU B operand and go through MEM.
    function automatic logic is_mem_op(input opcode_t op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    // Register-register ALU ops that finish with a writeback.
    function automatic logic is_rtype(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INV) || (op == OP_LSL) ||
               (op == OP_LSR) || (op == OP_AND) || (op == OP_OR)  || (op == OP_SLT);
    endfunction

    function automatic logic is_illegal(input opcode_t op);
        return (op == OP_ILL_A) || (op == OP_ILL_E);
    endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Pure combinational decoder: FSM state + latched opcode (+ mem_ready, alu_zero)
// to datapath/memory strobes. Holds no state of its own.
module ctrl_output_decode #(
    parameter int unsigned OPCODE_W = 4
) (
    input  cpu_ctrl_pkg::state_e  state,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic                  mem_ready,
    input  logic                  alu_zero,
    output logic                  mem_req,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic                  ir_load,
    output logic                  pc_inc,
    output logic                  pc_load,
    output logic                  reg_write,
    output logic                  mem_to_reg,
    output logic                  alu_src_imm,
    output logic                  alu_op_valid,
    output logic [OPCODE_W-1:0]   ALU_control_in,
    output logic                  halted
);
    import cpu_ctrl_pkg::*;

    // Strobe decode; every output defaults low, ALU opcode always tracks opcode_q.
    always_comb begin
        mem_req        = 1'b0;
        mem_rd         = 1'b0;
        mem_wr         = 1'b0;
        ir_load        = 1'b0;
        pc_inc         = 1'b0;
        pc_load        = 1'b0;
        reg_write      = 1'b0;
        mem_to_reg     = 1'b0;
        alu_src_imm    = 1'b0;
        alu_op_valid   = 1'b0;
        halted         = 1'b0;
        ALU_control_in = opcode;

        unique case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                mem_rd  = 1'b1;
                ir_load = mem_ready;
                pc_inc  = mem_ready;
            end
            S_EXEC: begin
                alu_src_imm = is_mem_op(opcode);
                // JMP needs no ALU result; the target comes straight from the IR.
                if (opcode == OP_JMP) begin
                    pc_load = 1'b1;
                end else begin
                    alu_op_valid = 1'b1;
                end
                if (opcode == OP_BEQ) pc_load = alu_zero;
                if (opcode == OP_BNE) pc_load = !alu_zero;
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_rd       = (opcode == OP_LD);
                mem_wr       = (opcode == OP_ST);
                // Keep the ALU computing base+imm so the address stays stable.
                alu_src_imm  = 1'b1;
                alu_op_valid = 1'b1;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (opcode == OP_LD);
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                // S_RST and S_DECODE drive nothing.
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle main control unit: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Optional performance counters (cycle_cnt, instr_retired) are enabled by
// defining CTRL_PERF_CNT_EN.
module multicycle_control_fsm #(
    parameter int unsigned OPCODE_W = 4
`ifdef CTRL_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W    = 32
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] instr_opcode,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                ir_load,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                alu_src_imm,
    output logic                alu_op_valid,
    output logic [OPCODE_W-1:0] ALU_control_in,
    output logic                halted,
    output logic                illegal_op
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    instr_retired
`endif
);
    import cpu_ctrl_pkg::*;

    state_e                state_q, state_d;
    logic [OPCODE_W-1:0]   opcode_q, opcode_d;
    logic                  illegal_q, illegal_d;

    // State, opcode and sticky illegal flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RST;
            opcode_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic; FETCH and MEM hold until memory completes the request.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        illegal_d = illegal_q;

        unique case (state_q)
            S_RST: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    opcode_d = instr_opcode;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opcode_q == OP_HALT) begin
                    state_d = S_HALT;
                end else if (is_illegal(opcode_q)) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_mem_op(opcode_q)) begin
                    state_d = S_MEM;
                end else if (is_rtype(opcode_q)) begin
                    state_d = S_WB;
                end else begin
                    // BEQ/BNE/JMP complete here.
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (opcode_q == OP_LD) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_RST;
            end
        endcase
    end

    ctrl_output_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .state          (state_q),
        .opcode         (opcode_q),
        .mem_ready      (mem_ready),
        .alu_zero       (alu_zero),
        .mem_req        (mem_req),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .ir_load        (ir_load),
        .pc_inc         (pc_inc),
        .pc_load        (pc_load),
        .reg_write      (reg_write),
        .mem_to_reg     (mem_to_reg),
        .alu_src_imm    (alu_src_imm),
        .alu_op_valid   (alu_op_valid),
        .ALU_control_in (ALU_control_in),
        .halted         (halted)
    );

    assign illegal_op = illegal_q;

`ifdef CTRL_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CntOne = 1;

    logic [CNT_W-1:0] cycle_q, retired_q;
    logic             retire;

    // An instruction retires when control returns to FETCH from its last state.
    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));

    // Free-running counters; frozen in RST and HALT, wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            if ((state_q != S_RST) && (state_q != S_HALT)) cycle_q <= cycle_q + CntOne;
            if (retire) retired_q <= retired_q + CntOne;
        end
    end

    assign cycle_cnt     = cycle_q;
    assign instr_retired = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed testbench for multicycle_control_fsm. Outputs are packed into one
// vector and compared cycle by cycle against hand-computed values.
module tb_multicycle_control_fsm;
    import cpu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] instr_opcode;
    logic       alu_zero;
    logic       mem_ready;
    logic       mem_req, mem_rd, mem_wr, ir_load, pc_inc, pc_load;
    logic       reg_write, mem_to_reg, alu_src_imm, alu_op_valid, halted, illegal_op;
    logic [3:0] ALU_control_in;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_retired;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk            (clk),
        .rst            (rst),
        .instr_opcode   (instr_opcode),
        .alu_zero       (alu_zero),
        .mem_ready      (mem_ready),
        .mem_req        (mem_req),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .ir_load        (ir_load),
        .pc_inc         (pc_inc),
        .pc_load        (pc_load),
        .reg_write      (reg_write),
        .mem_to_reg     (mem_to_reg),
        .alu_src_imm    (alu_src_imm),
        .alu_op_valid   (alu_op_valid),
        .ALU_control_in (ALU_control_in),
        .halted         (halted),
        .illegal_op     (illegal_op)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cycle_cnt      (cycle_cnt),
        .instr_retired  (instr_retired)
`endif
    );

    localparam logic [15:0] REQ = 16'h8000;
    localparam logic [15:0] RD  = 16'h4000;
    localparam logic [15:0] WR  = 16'h2000;
    localparam logic [15:0] IR  = 16'h1000;
    localparam logic [15:0] PCI = 16'h0800;
    localparam logic [15:0] PCL = 16'h0400;
    localparam logic [15:0] RW  = 16'h0200;
    localparam logic [15:0] M2R = 16'h0100;
    localparam logic [15:0] IMM = 16'h0080;
    localparam logic [15:0] VAL = 16'h0040;
    localparam logic [15:0] HLT = 16'h0020;
    localparam logic [15:0] ILL = 16'h0010;
    localparam logic [15:0] ALL = 16'hFFFF;

    logic [15:0] outs;
    assign outs = {mem_req, mem_rd, mem_wr, ir_load, pc_inc, pc_load, reg_write, mem_to_reg,
                   alu_src_imm, alu_op_valid, halted, illegal_op, ALU_control_in};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at edge+1 with inputs already set: check at edge+2, then advance a cycle.
    task automatic cyc(input string tag, input state_e st, input logic [15:0] exp,
                       input logic [15:0] mask);
        #1;
        check_eq({tag, " state"}, 32'(dut.state_q), 32'(st));
        check_eq({tag, " outs"}, 32'(outs & mask), 32'(exp & mask));
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst          = 1'b1;
        mem_ready    = 1'b0;
        alu_zero     = 1'b0;
        instr_opcode = 4'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("rst", S_RST, 16'h0000, ALL);
    endtask

`ifdef CTRL_PERF_CNT_EN
    task automatic perf_test();
        logic [3:0] prog [3];
        int pc;
        prog[0] = OP_ADD;
        prog[1] = OP_ST;
        prog[2] = OP_HALT;
        reset_dut();
        check_eq("perf cyc rst", cycle_cnt, 32'd0);
        check_eq("perf ret rst", instr_retired, 32'd0);
        mem_ready = 1'b1;
        pc = 0;
        for (int i = 0; i < 40 && !halted; i++) begin
            instr_opcode = prog[(pc < 3) ? pc : 2];
            #1;
            if (pc_inc) pc++;
            @(posedge clk);
            #1;
        end
        check_eq("perf halted", 32'(halted), 32'd1);
        check_eq("perf cyc", cycle_cnt, 32'd10);
        check_eq("perf ret", instr_retired, 32'd2);
        repeat (5) @(posedge clk);
        #1;
        check_eq("perf cyc frozen", cycle_cnt, 32'd10);
        check_eq("perf ret frozen", instr_retired, 32'd2);
    endtask
`endif

    initial begin
        rst          = 1'b1;
        mem_ready    = 1'b0;
        alu_zero     = 1'b0;
        instr_opcode = 4'd0;

        // ADD, zero wait states
        reset_dut();
        instr_opcode = OP_ADD;
        mem_ready    = 1'b1;
        cyc("add fetch", S_FETCH, REQ | RD | IR | PCI, ALL);
        cyc("add decode", S_DECODE, 16'h0002, ALL);
        cyc("add exec", S_EXEC, VAL | 16'h0002, ALL);
        cyc("add wb", S_WB, RW | 16'h0002, ALL);
        cyc("add refetch", S_FETCH, REQ | RD | IR | PCI | 16'h0002, ALL);

        // LD with two wait cycles in FETCH and MEM
        reset_dut();
        instr_opcode = OP_LD;
        cyc("ld fetch w1", S_FETCH, REQ | RD, ALL);
        cyc("ld fetch w2", S_FETCH, REQ | RD, ALL);
        mem_ready = 1'b1;
        cyc("ld fetch", S_FETCH, REQ | RD | IR | PCI, ALL);
        mem_ready = 1'b0;
        cyc("ld decode", S_DECODE, 16'h0000, ALL);
        cyc("ld exec", S_EXEC, VAL | IMM, ALL);
        cyc("ld mem w1", S_MEM, REQ | RD | IMM, ~VAL);
        cyc("ld mem w2", S_MEM, REQ | RD | IMM, ~VAL);
        mem_ready = 1'b1;
        cyc("ld mem", S_MEM, REQ | RD | IMM, ~VAL);
        mem_ready = 1'b0;
        cyc("ld wb", S_WB, RW | M2R, ALL);
        cyc("ld refetch", S_FETCH, REQ | RD, ALL);

        // BEQ taken, BNE not taken, JMP
        reset_dut();
        mem_ready    = 1'b1;
        instr_opcode = OP_BEQ;
        cyc("beq fetch", S_FETCH, REQ | RD | IR | PCI, ALL);
        cyc("beq decode", S_DECODE, 16'h000B, ALL);
        alu_zero = 1'b1;
        cyc("beq exec", S_EXEC, VAL | PCL | 16'h000B, ALL);
        instr_opcode = OP_BNE;
        cyc("bne fetch", S_FETCH, REQ | RD | IR | PCI | 16'h000B, ALL);
        cyc("bne decode", S_DECODE, 16'h000C, ALL);
        cyc("bne exec", S_EXEC, VAL | 16'h000C, ALL);
        instr_opcode = OP_JMP;
        cyc("jmp fetch", S_FETCH, REQ | RD | IR | PCI | 16'h000C, ALL);
        cyc("jmp decode", S_DECODE, 16'h000D, ALL);
        cyc("jmp exec", S_EXEC, PCL | 16'h000D, ALL);
        mem_ready = 1'b0;
        cyc("jmp refetch", S_FETCH, REQ | RD | 16'h000D, ALL);

        // Illegal opcode 10 halts with the sticky flag; only rst leaves HALT
        reset_dut();
        mem_ready    = 1'b1;
        instr_opcode = 4'd10;
        cyc("ill fetch", S_FETCH, REQ | RD | IR | PCI, ALL);
        cyc("ill decode", S_DECODE, 16'h000A, ALL);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            cyc("ill halt", S_HALT, HLT | ILL | 16'h000A, ALL);
        end
        reset_dut();

        // rst in the middle of an ST memory wait
        mem_ready    = 1'b1;
        instr_opcode = OP_ST;
        cyc("st fetch", S_FETCH, REQ | RD | IR | PCI, ALL);
        cyc("st decode", S_DECODE, 16'h0001, ALL);
        cyc("st exec", S_EXEC, VAL | IMM | 16'h0001, ALL);
        mem_ready = 1'b0;
        cyc("st mem w1", S_MEM, REQ | WR | IMM | 16'h0001, ~VAL);
        rst = 1'b1;
        cyc("st mem w2", S_MEM, REQ | WR | IMM | 16'h0001, ~VAL);
        rst = 1'b0;
        cyc("st rst", S_RST, 16'h0000, ALL);
        for (int i = 0; i < 3; i++) begin
            cyc("st after rst", S_FETCH, REQ | RD, ALL);
        end

`ifdef CTRL_PERF_CNT_EN
        perf_test();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
